// File: rtl/col_progress_tracker.sv
//==============================================================================
// Module      : col_progress_tracker
// Description : Counts fully completed solver columns for the column PIO and
//               reports frame busy/done, frame cycle count and sequencing error.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module col_progress_tracker #(
  parameter int NUM_COLS = 640,
  parameter int NUM_ROWS = 480,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [COL_W-1:0] pix_col,
  input  logic [ROW_W-1:0] pix_row,
  output logic [COL_W-1:0] col_out,
  output logic             busy,
  output logic             frame_done,
  output logic [31:0]      cycle_count,
  output logic             seq_err
);

  localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [COL_W-1:0] c_NUM_COLS = COL_W'(NUM_COLS);
  localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(NUM_ROWS - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state,      w_state_nxt;
  logic [COL_W-1:0] r_cur_col,    w_cur_col_nxt;
  logic [ROW_W-1:0] r_row_cnt,    w_row_cnt_nxt;
  logic [COL_W-1:0] r_col_out,    w_col_out_nxt;
  logic [CNT_W-1:0] r_cycle_cnt,  w_cycle_cnt_nxt;
  logic             r_busy,       w_busy_nxt;
  logic             r_frame_done, w_frame_done_nxt;
  logic             r_seq_err,    w_seq_err_nxt;
  logic             w_pix_match;

  assign w_pix_match = pix_valid && (pix_col == r_cur_col) && (pix_row == r_row_cnt);

  always_comb begin
    w_state_nxt      = r_state;
    w_cur_col_nxt    = r_cur_col;
    w_row_cnt_nxt    = r_row_cnt;
    w_col_out_nxt    = r_col_out;
    w_cycle_cnt_nxt  = r_cycle_cnt;
    w_busy_nxt       = r_busy;
    w_frame_done_nxt = 1'b0;
    w_seq_err_nxt    = r_seq_err;

    // frame_start restarts from any state and overrides a same-cycle pixel
    if (frame_start) begin
      w_state_nxt     = S_RUN;
      w_cur_col_nxt   = '0;
      w_row_cnt_nxt   = '0;
      w_col_out_nxt   = '0;
      w_cycle_cnt_nxt = '0;
      w_busy_nxt      = 1'b1;
      w_seq_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (r_cycle_cnt != c_CNT_MAX) begin
            w_cycle_cnt_nxt = r_cycle_cnt + CNT_W'(1);
          end
          if (w_pix_match) begin
            if (r_row_cnt == c_LAST_ROW) begin
              w_row_cnt_nxt = '0;
              w_cur_col_nxt = r_cur_col + COL_W'(1);
              if (r_cur_col == c_LAST_COL) begin
                w_col_out_nxt    = c_NUM_COLS;
                w_busy_nxt       = 1'b0;
                w_frame_done_nxt = 1'b1;
                w_state_nxt      = S_DONE;
              end else begin
                w_col_out_nxt = r_cur_col + COL_W'(1);
              end
            end else begin
              w_row_cnt_nxt = r_row_cnt + ROW_W'(1);
            end
          end else if (pix_valid) begin
            w_seq_err_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cur_col    <= '0;
      r_row_cnt    <= '0;
      r_col_out    <= '0;
      r_cycle_cnt  <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_seq_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_col    <= w_cur_col_nxt;
      r_row_cnt    <= w_row_cnt_nxt;
      r_col_out    <= w_col_out_nxt;
      r_cycle_cnt  <= w_cycle_cnt_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_seq_err    <= w_seq_err_nxt;
    end
  end

  assign col_out     = r_col_out;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign cycle_count = 32'(r_cycle_cnt);
  assign seq_err     = r_seq_err;

endmodule

`default_nettype wire

// File: tb/tb_col_progress_tracker.sv
//==============================================================================
// Module      : tb_col_progress_tracker
// Description : Directed self-checking bench for col_progress_tracker.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_col_progress_tracker;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // small frame 4x3
  logic        fs0 = 0, pv0 = 0;
  logic [9:0]  pc0 = 0;
  logic [8:0]  pr0 = 0;
  logic [9:0]  col0;
  logic        busy0, done0, err0;
  logic [31:0] cc0;

  // 640 columns, single row, gapped input
  logic        fs1 = 0, pv1 = 0;
  logic [9:0]  pc1 = 0;
  logic [8:0]  pr1 = 0;
  logic [9:0]  col1;
  logic        busy1, done1, err1;
  logic [31:0] cc1;

  // single column, 3-bit cycle counter for saturation
  logic        fs2 = 0, pv2 = 0;
  logic [9:0]  pc2 = 0;
  logic [8:0]  pr2 = 0;
  logic [9:0]  col2;
  logic        busy2, done2, err2;
  logic [31:0] cc2;

  col_progress_tracker #(.NUM_COLS(4), .NUM_ROWS(3)) u_small (
    .clk(clk), .reset_n(reset_n), .frame_start(fs0), .pix_valid(pv0),
    .pix_col(pc0), .pix_row(pr0), .col_out(col0), .busy(busy0),
    .frame_done(done0), .cycle_count(cc0), .seq_err(err0));

  col_progress_tracker #(.NUM_COLS(640), .NUM_ROWS(1)) u_wide (
    .clk(clk), .reset_n(reset_n), .frame_start(fs1), .pix_valid(pv1),
    .pix_col(pc1), .pix_row(pr1), .col_out(col1), .busy(busy1),
    .frame_done(done1), .cycle_count(cc1), .seq_err(err1));

  col_progress_tracker #(.NUM_COLS(1), .NUM_ROWS(2), .CNT_W(3)) u_sat (
    .clk(clk), .reset_n(reset_n), .frame_start(fs2), .pix_valid(pv2),
    .pix_col(pc2), .pix_row(pr2), .col_out(col2), .busy(busy2),
    .frame_done(done2), .cycle_count(cc2), .seq_err(err2));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px0(input int c, input int r);
    pv0 = 1; pc0 = 10'(c); pr0 = 9'(r);
    tick();
    pv0 = 0;
  endtask

  task automatic start0();
    fs0 = 1;
    tick();
    fs0 = 0;
  endtask

  int run_cycles;
  int changes;
  int done_pulses;
  logic [9:0] prev_col;

  initial begin
    // reset, then reset asserted in the middle of a running frame
    repeat (2) tick();
    chk("rst_col", 32'(col0), 0);
    chk("rst_busy", 32'(busy0), 0);
    reset_n = 1;
    tick();
    start0();
    px0(0, 0); px0(0, 1); px0(0, 2);
    chk("pre_rst_col", 32'(col0), 1);
    #2 reset_n = 0;
    #1;
    chk("async_rst_col", 32'(col0), 0);
    chk("async_rst_busy", 32'(busy0), 0);
    chk("async_rst_cc", cc0, 0);
    chk("async_rst_done", 32'(done0), 0);
    chk("async_rst_err", 32'(err0), 0);
    tick();
    reset_n = 1;
    tick();
    px0(0, 0); px0(0, 1); px0(0, 2); px0(1, 0);
    chk("idle_ign_col", 32'(col0), 0);
    chk("idle_ign_err", 32'(err0), 0);
    chk("idle_ign_busy", 32'(busy0), 0);
    chk("idle_ign_cc", cc0, 0);

    // in-order frame, one pixel per cycle
    start0();
    chk("start_busy", 32'(busy0), 1);
    chk("start_cc", cc0, 0);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 3; r++) begin
        px0(c, r);
        if (r == 2) chk("col_step", 32'(col0), 32'(c + 1));
        else        chk("col_hold", 32'(col0), 32'(c));
        if (!(c == 3 && r == 2)) chk("done_low", 32'(done0), 0);
      end
    end
    chk("frame_done", 32'(done0), 1);
    chk("busy_drop", 32'(busy0), 0);
    chk("cc_frame", cc0, 12);
    tick();
    chk("done_one_cycle", 32'(done0), 0);
    px0(0, 0); px0(1, 1);
    chk("done_ign_col", 32'(col0), 4);
    chk("done_ign_err", 32'(err0), 0);
    chk("done_cc_frozen", cc0, 12);

    // out-of-order pixel
    start0();
    chk("restart_col", 32'(col0), 0);
    px0(0, 0);
    px0(0, 2);
    chk("ooo_err", 32'(err0), 1);
    chk("ooo_col", 32'(col0), 0);
    px0(0, 1);
    px0(0, 2);
    chk("ooo_complete_col", 32'(col0), 1);
    chk("ooo_err_sticky", 32'(err0), 1);
    start0();
    chk("err_cleared", 32'(err0), 0);

    // abort with colliding pixel
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 3; r++) px0(c, r);
    chk("abort_pre_col", 32'(col0), 2);
    fs0 = 1; pv0 = 1; pc0 = 0; pr0 = 0;
    tick();
    fs0 = 0; pv0 = 0;
    chk("abort_col", 32'(col0), 0);
    chk("abort_cc", cc0, 0);
    chk("abort_busy", 32'(busy0), 1);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 3; r++) px0(c, r);
    chk("abort_frame_col", 32'(col0), 4);
    chk("abort_frame_done", 32'(done0), 1);
    chk("abort_pix_dropped", 32'(err0), 0);
    chk("abort_frame_cc", cc0, 12);

    // 640 single-row columns with random gaps
    fs1 = 1;
    tick();
    fs1 = 0;
    run_cycles = 0; changes = 0; done_pulses = 0; prev_col = 0;
    for (int c = 0; c < 640; c++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        tick();
        run_cycles++;
        if (col1 != prev_col) changes++;
        if (done1) done_pulses++;
      end
      pv1 = 1; pc1 = 10'(c); pr1 = 0;
      tick();
      pv1 = 0;
      run_cycles++;
      if (col1 != prev_col) begin
        changes++;
        if (col1 != prev_col + 10'd1) chk("wide_monotonic", 32'(col1), 32'(prev_col) + 1);
        prev_col = col1;
      end
      if (done1) done_pulses++;
    end
    repeat (3) begin
      tick();
      if (col1 != prev_col) changes++;
      if (done1) done_pulses++;
    end
    chk("wide_col", 32'(col1), 640);
    chk("wide_changes", 32'(changes), 640);
    chk("wide_done_pulses", 32'(done_pulses), 1);
    chk("wide_cc", cc1, 32'(run_cycles));
    chk("wide_busy", 32'(busy1), 0);
    chk("wide_err", 32'(err1), 0);

    // saturation with a 3-bit counter, single-column frame
    fs2 = 1;
    tick();
    fs2 = 0;
    repeat (6) tick();
    chk("sat_pre", cc2, 6);
    repeat (4) tick();
    chk("sat_hold", cc2, 7);
    pv2 = 1; pc2 = 0; pr2 = 0;
    tick();
    chk("sat_row0_col", 32'(col2), 0);
    pr2 = 1;
    tick();
    pv2 = 0;
    chk("sat_col", 32'(col2), 1);
    chk("sat_done", 32'(done2), 1);
    chk("sat_cc", cc2, 7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
